// File: rtl/wb_pipe_mem.sv
// Pipelined Wishbone B4 slave memory: an in-order queue of up to QDEPTH requests.
// Each request completes max(access_time,1) cycles after acceptance; stall_o is asserted while the queue is full.
module wb_pipe_mem #(
    parameter int ADR_W  = 13,
    parameter int QDEPTH = 4,
    parameter int LAT_W  = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [LAT_W-1:0] access_time,
    input  logic             cyc_i,
    input  logic             stb_i,
    input  logic             we_i,
    input  logic [3:0]       sel_i,
    input  logic [ADR_W-1:0] adr_i,
    input  logic [31:0]      dat_i,
    output logic [31:0]      dat_o,
    output logic             ack_o,
    output logic             stall_o
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    logic [31:0]      r_mem   [0:(2**ADR_W)-1];
    logic             r_q_we  [QDEPTH];
    logic [3:0]       r_q_sel [QDEPTH];
    logic [ADR_W-1:0] r_q_adr [QDEPTH];
    logic [31:0]      r_q_dat [QDEPTH];
    logic [LAT_W-1:0] r_q_cnt [QDEPTH];
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [CW-1:0]    r_count;
    logic             r_ack;
    logic [31:0]      r_dat;

    logic             w_full;
    logic             w_acc;
    logic             w_done;
    logic [LAT_W-1:0] w_lat;

    assign w_full  = (r_count == CW'(QDEPTH));
    assign stall_o = w_full;
    assign w_acc   = cyc_i & stb_i & ~w_full;
    assign w_lat   = (access_time == '0) ? LAT_W'(1) : access_time;
    // A head counter of 1 reaches zero at this edge; 0 means it expired while waiting behind an older entry.
    assign w_done  = cyc_i & (r_count != '0) & (r_q_cnt[r_head] <= LAT_W'(1));
    assign ack_o   = r_ack;
    assign dat_o   = r_dat;

    always_ff @(posedge clk_i) begin
        if (w_acc) begin
            r_q_we[r_tail]  <= we_i;
            r_q_sel[r_tail] <= sel_i;
            r_q_adr[r_tail] <= adr_i;
            r_q_dat[r_tail] <= dat_i;
        end
    end

    // The write is performed at completion, so queued reads observe every older write.
    always_ff @(posedge clk_i) begin
        if (w_done && r_q_we[r_head]) begin
            for (int b = 0; b < 4; b++) begin
                if (r_q_sel[r_head][b]) begin
                    r_mem[r_q_adr[r_head]][8*b +: 8] <= r_q_dat[r_head][8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_ack   <= 1'b0;
            r_dat   <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                r_q_cnt[i] <= '0;
            end
        end else if (!cyc_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_ack   <= 1'b0;
            for (int i = 0; i < QDEPTH; i++) begin
                r_q_cnt[i] <= '0;
            end
        end else begin
            r_ack <= w_done;
            if (w_done) begin
                r_head <= r_head + 1'b1;
                if (!r_q_we[r_head]) begin
                    r_dat <= r_mem[r_q_adr[r_head]];
                end
            end
            if (w_acc) begin
                r_tail <= r_tail + 1'b1;
            end
            case ({w_acc, w_done})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            for (int i = 0; i < QDEPTH; i++) begin
                if (w_acc && (PW'(i) == r_tail)) begin
                    r_q_cnt[i] <= w_lat;
                end else if (r_q_cnt[i] != '0) begin
                    r_q_cnt[i] <= r_q_cnt[i] - 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_wb_pipe_mem.sv
// Bench for wb_pipe_mem: directed vector table, hand-written corner sequences and random traffic,
// all cross-checked each cycle against a queue-based reference model.
module tb_wb_pipe_mem;
    localparam int ADR_W  = 13;
    localparam int QDEPTH = 4;
    localparam int LAT_W  = 4;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b0;
    logic [LAT_W-1:0] access_time = '0;
    logic             cyc_i = 1'b0;
    logic             stb_i = 1'b0;
    logic             we_i  = 1'b0;
    logic [3:0]       sel_i = '0;
    logic [ADR_W-1:0] adr_i = '0;
    logic [31:0]      dat_i = '0;
    logic [31:0]      dat_o;
    logic             ack_o;
    logic             stall_o;

    int n_tests = 0;
    int n_fail  = 0;

    wb_pipe_mem #(.ADR_W(ADR_W), .QDEPTH(QDEPTH), .LAT_W(LAT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .access_time(access_time),
        .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i), .sel_i(sel_i),
        .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o), .ack_o(ack_o), .stall_o(stall_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: each request is due at (accept edge + L) and leaves in order, one per edge.
    typedef struct {
        logic             we;
        logic [3:0]       sel;
        logic [ADR_W-1:0] adr;
        logic [31:0]      dat;
        int               ready;
    } req_t;

    req_t        mq[$];
    logic [31:0] mm [16];
    logic        m_ack  = 1'b0;
    logic [31:0] m_dat  = '0;
    int          m_edge = 0;

    always @(posedge clk_i or negedge rst_i) begin
        bit   full;
        req_t r;
        if (!rst_i) begin
            mq.delete();
            m_ack = 1'b0;
            m_dat = '0;
        end else begin
            m_edge++;
            full  = (mq.size() == QDEPTH);
            m_ack = 1'b0;
            if (!cyc_i) begin
                mq.delete();
            end else begin
                if (mq.size() > 0 && mq[0].ready <= m_edge) begin
                    r = mq.pop_front();
                    m_ack = 1'b1;
                    if (r.we) begin
                        for (int b = 0; b < 4; b++)
                            if (r.sel[b]) mm[r.adr[3:0]][8*b +: 8] = r.dat[8*b +: 8];
                    end else begin
                        m_dat = mm[r.adr[3:0]];
                    end
                end
                if (stb_i && !full)
                    mq.push_back('{we_i, sel_i, adr_i, dat_i,
                                   m_edge + ((access_time == 0) ? 1 : int'(access_time))});
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_chk();
        chk("model_ack",   32'(ack_o),   32'(m_ack));
        chk("model_stall", 32'(stall_o), 32'(mq.size() == QDEPTH));
        chk("model_dat",   dat_o,        m_dat);
    endtask

    task automatic step(input logic c, input logic s, input logic w, input logic [3:0] sl,
                        input logic [ADR_W-1:0] a, input logic [31:0] d, input logic [LAT_W-1:0] at);
        cyc_i = c; stb_i = s; we_i = w; sel_i = sl; adr_i = a; dat_i = d; access_time = at;
        @(posedge clk_i);
        @(negedge clk_i);
        model_chk();
    endtask

    task automatic preload(input int a, input logic [31:0] v);
        dut.r_mem[a] = v;
        mm[a]        = v;
    endtask

    typedef struct {
        logic             cyc, stb, we;
        logic [3:0]       sel;
        logic [ADR_W-1:0] adr;
        logic [31:0]      dat;
        logic [LAT_W-1:0] at;
        logic             e_ack, e_stall, chk_dat;
        logic [31:0]      e_dat;
    } vec_t;

    vec_t        vt[$];
    logic [31:0] saved9, saved10;

    initial begin
        for (int i = 0; i < 16; i++) preload(i, $urandom());
        for (int i = 0; i < 4; i++) preload(i, 32'hA0A0_0000 + 32'(i));
        preload(5, 32'hDEADBEEF);
        preload(7, 32'h11223344);

        // single read, L=3
        vt.push_back('{1, 1, 0, 4'h0, 13'd5, 32'h0, 4'd3, 0, 0, 0, 32'h0});
        vt.push_back('{1, 0, 0, 4'h0, 13'd0, 32'h0, 4'd3, 0, 0, 0, 32'h0});
        vt.push_back('{1, 0, 0, 4'h0, 13'd0, 32'h0, 4'd3, 0, 0, 0, 32'h0});
        vt.push_back('{1, 0, 0, 4'h0, 13'd0, 32'h0, 4'd3, 1, 0, 1, 32'hDEADBEEF});
        vt.push_back('{1, 0, 0, 4'h0, 13'd0, 32'h0, 4'd3, 0, 0, 1, 32'hDEADBEEF});
        // back-to-back reads, L=2
        vt.push_back('{1, 1, 0, 4'h0, 13'd0, 32'h0, 4'd2, 0, 0, 0, 32'h0});
        vt.push_back('{1, 1, 0, 4'h0, 13'd1, 32'h0, 4'd2, 0, 0, 0, 32'h0});
        vt.push_back('{1, 1, 0, 4'h0, 13'd2, 32'h0, 4'd2, 1, 0, 1, 32'hA0A00000});
        vt.push_back('{1, 1, 0, 4'h0, 13'd3, 32'h0, 4'd2, 1, 0, 1, 32'hA0A00001});
        vt.push_back('{1, 0, 0, 4'h0, 13'd0, 32'h0, 4'd2, 1, 0, 1, 32'hA0A00002});
        vt.push_back('{1, 0, 0, 4'h0, 13'd0, 32'h0, 4'd2, 1, 0, 1, 32'hA0A00003});
        vt.push_back('{1, 0, 0, 4'h0, 13'd0, 32'h0, 4'd2, 0, 0, 1, 32'hA0A00003});
        // byte-lane write then immediate read
        vt.push_back('{1, 1, 1, 4'h5, 13'd7, 32'hAABBCCDD, 4'd2, 0, 0, 1, 32'hA0A00003});
        vt.push_back('{1, 1, 0, 4'h0, 13'd7, 32'h0, 4'd2, 0, 0, 0, 32'h0});
        vt.push_back('{1, 0, 0, 4'h0, 13'd0, 32'h0, 4'd2, 1, 0, 1, 32'hA0A00003});
        vt.push_back('{1, 0, 0, 4'h0, 13'd0, 32'h0, 4'd2, 1, 0, 1, 32'h11BB33DD});
        vt.push_back('{1, 0, 0, 4'h0, 13'd0, 32'h0, 4'd2, 0, 0, 1, 32'h11BB33DD});

        repeat (2) @(negedge clk_i);
        chk("reset_ack",   32'(ack_o),   32'h0);
        chk("reset_stall", 32'(stall_o), 32'h0);
        chk("reset_dat",   dat_o,        32'h0);
        rst_i = 1'b1;
        step(1, 0, 0, 4'h0, '0, '0, 4'd1);

        foreach (vt[i]) begin
            step(vt[i].cyc, vt[i].stb, vt[i].we, vt[i].sel, vt[i].adr, vt[i].dat, vt[i].at);
            chk($sformatf("vec%0d_ack", i),   32'(ack_o),   32'(vt[i].e_ack));
            chk($sformatf("vec%0d_stall", i), 32'(stall_o), 32'(vt[i].e_stall));
            if (vt[i].chk_dat) chk($sformatf("vec%0d_dat", i), dat_o, vt[i].e_dat);
        end

        // full queue: L=8, strobe held until the 5th request gets in
        for (int i = 0; i < 19; i++) begin
            step(1, (i <= 9), 0, 4'h0, 13'd8, '0, 4'd8);
            chk($sformatf("full%0d_stall", i), 32'(stall_o), 32'((i >= 3) && (i <= 7)));
            chk($sformatf("full%0d_ack", i), 32'(ack_o),
                32'((i >= 8 && i <= 11) || i == 17));
        end

        // abort: two writes flushed before completing
        saved9  = mm[9];
        saved10 = mm[10];
        step(1, 1, 1, 4'hF, 13'd9,  32'h55555555, 4'd5);
        chk("abort_w0_ack", 32'(ack_o), 32'h0);
        step(1, 1, 1, 4'hF, 13'd10, 32'h66666666, 4'd5);
        chk("abort_w1_ack", 32'(ack_o), 32'h0);
        step(1, 0, 0, 4'h0, '0, '0, 4'd5);
        step(0, 0, 0, 4'h0, '0, '0, 4'd5);
        chk("abort_drop_ack", 32'(ack_o), 32'h0);
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 0, 4'h0, '0, '0, 4'd5);
            chk($sformatf("abort_idle%0d_ack", i), 32'(ack_o), 32'h0);
        end
        chk("abort_mem9",  dut.r_mem[9],  saved9);
        chk("abort_mem10", dut.r_mem[10], saved10);
        step(1, 1, 0, 4'h0, 13'd9, '0, 4'd5);
        for (int j = 1; j <= 5; j++) begin
            step(1, 0, 0, 4'h0, '0, '0, 4'd5);
            chk($sformatf("abort_rd%0d_ack", j), 32'(ack_o), 32'(j == 5));
        end
        chk("abort_rd_dat", dat_o, saved9);

        // reset with three requests outstanding and an ack on the wire
        for (int i = 0; i < 4; i++) step(1, 1, 0, 4'h0, ADR_W'(i), '0, 4'd3);
        chk("prerst_ack", 32'(ack_o), 32'h1);
        rst_i = 1'b0;
        #1;
        chk("rst_async_ack",   32'(ack_o),   32'h0);
        chk("rst_async_stall", 32'(stall_o), 32'h0);
        chk("rst_async_dat",   dat_o,        32'h0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 0, 4'h0, '0, '0, 4'd3);
            chk($sformatf("postrst%0d_ack", i), 32'(ack_o), 32'h0);
        end
        step(1, 1, 0, 4'h0, 13'd5, '0, 4'd0);
        chk("lat0_accept_ack", 32'(ack_o), 32'h0);
        step(1, 0, 0, 4'h0, '0, '0, 4'd0);
        chk("lat0_ack", 32'(ack_o), 32'h1);
        chk("lat0_dat", dat_o, 32'hDEADBEEF);

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic [LAT_W-1:0] at;
            at = ($urandom_range(0, 7) == 0) ? 4'd15 : LAT_W'($urandom_range(0, 5));
            step(($urandom_range(0, 39) != 0), ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)),
                 ADR_W'($urandom_range(0, 15)), $urandom(), at);
        end
        for (int i = 0; i < 20; i++) step(1, 0, 0, 4'h0, '0, '0, 4'd1);
        for (int i = 0; i < 16; i++) chk($sformatf("final_mem%0d", i), dut.r_mem[i], mm[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
